gbus_wr_arbiter: RTL and testbench



---
 rtl/gbus_arb_pkg.sv | 38 +++
 rtl/gbus_wr_arbiter_rr_picker.sv | 28 ++
 rtl/gbus_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_gbus_wr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbus_arb_pkg.sv
// Shared types and sizing for the global-bus write arbiter.
// Holds the FSM state encoding, the burst descriptor and destination decode helpers.
package gbus_arb_pkg;

    localparam int REQ_NUM   = 4;
    localparam int HNUM      = 8;
    localparam int VNUM      = 8;
    localparam int GBUS_DATA = 64;
    localparam int GBUS_ADDR = 12;
    localparam int MAX_BURST = 16;
    localparam int LEN_W     = $clog2(MAX_BURST);
    localparam int NCORE     = HNUM * VNUM;
    // One spare code point beyond the last core so an illegal destination is expressible.
    localparam int CORE_W    = $clog2(NCORE + 1);
    localparam int CIDX_W    = $clog2(NCORE);
    localparam int HEAD_W    = $clog2(HNUM);
    localparam int GNT_W     = $clog2(REQ_NUM);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0]     len;
        logic [CORE_W-1:0]    dst;
        logic [GBUS_ADDR-1:0] addr;
    } desc_t;

    function automatic logic dst_in_range(input logic [CORE_W-1:0] dst);
        return dst < CORE_W'(NCORE);
    endfunction

    function automatic logic [HEAD_W-1:0] dst_head(input logic [CORE_W-1:0] dst);
        return HEAD_W'(dst / CORE_W'(VNUM));
    endfunction

endpackage

// File: rtl/gbus_wr_arbiter_rr_picker.sv
// Round-robin priority encoder: first set request at or above ptr, wrapping.
// Purely combinational, no backpressure.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_o,
    output logic         any_o
);

    logic [W-1:0] idx;

    // Scan from the far end down so the nearest request to ptr is written last and wins.
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        any_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr_i) + i) % N);
            if (req_i[idx]) begin
                gnt_o = idx;
            end
        end
    end

endmodule

// File: rtl/gbus_wr_arbiter.sv
// Round-robin burst arbiter driving the core-array global-bus write port.
// Grant: 1 cycle in IDLE; beat accepted at N appears on gbus at N+1.
// Backpressure: beat_rdy drops combinationally while the destination core's stall is high.
module gbus_wr_arbiter
    import gbus_arb_pkg::*;
(
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [REQ_NUM-1:0]           req_vld,
    input  logic [REQ_NUM*LEN_W-1:0]     req_len,
    input  logic [REQ_NUM*CORE_W-1:0]    req_dst,
    input  logic [REQ_NUM*GBUS_ADDR-1:0] req_addr,
    output logic [REQ_NUM-1:0]           req_ack,
    input  logic [REQ_NUM-1:0]           beat_vld,
    input  logic [REQ_NUM*GBUS_DATA-1:0] beat_data,
    output logic [REQ_NUM-1:0]           beat_rdy,
    input  logic [NCORE-1:0]             dst_stall,
    output logic [NCORE-1:0]             gbus_wen,
    output logic [HNUM*GBUS_DATA-1:0]    gbus_wdata,
    output logic [HNUM*GBUS_ADDR-1:0]    in_GBUS_ADDR,
    output logic                         busy,
    output logic [GNT_W-1:0]             grant_id,
    output logic                         err_dst
);

    state_e                            state_q, state_d;
    logic [GNT_W-1:0]                  rr_ptr_q;
    logic [GNT_W-1:0]                  gnt_q;
    logic [GNT_W-1:0]                  pick;
    logic                              pick_any;
    desc_t                             pick_desc;
    desc_t                             desc_q;
    logic [LEN_W-1:0]                  len_cnt_q;
    logic [REQ_NUM-1:0]                ack_q;
    logic                              err_q;
    logic [NCORE-1:0]                  wen_q;
    logic [HNUM-1:0][GBUS_DATA-1:0]    wdata_q;
    logic [HNUM-1:0][GBUS_ADDR-1:0]    waddr_q;
    logic                              dst_ok;
    logic                              dst_stalled;
    logic                              accept;
    logic                              last_beat;
    logic [GBUS_DATA-1:0]              cur_data;

    rr_picker #(
        .N (REQ_NUM),
        .W (GNT_W)
    ) u_rr_picker (
        .req_i (req_vld),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick),
        .any_o (pick_any)
    );

    always_comb begin
        pick_desc.len  = req_len[pick*LEN_W +: LEN_W];
        pick_desc.dst  = req_dst[pick*CORE_W +: CORE_W];
        pick_desc.addr = req_addr[pick*GBUS_ADDR +: GBUS_ADDR];
    end

    // Illegal destinations never look stalled, so their bursts always drain.
    assign dst_ok      = dst_in_range(desc_q.dst);
    assign dst_stalled = dst_ok && dst_stall[desc_q.dst[CIDX_W-1:0]];
    assign cur_data    = beat_data[gnt_q*GBUS_DATA +: GBUS_DATA];
    assign accept      = (state_q == BURST) && beat_vld[gnt_q] && !dst_stalled;
    assign last_beat   = accept && (len_cnt_q == desc_q.len);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any)  state_d = BURST;
            BURST:   if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_rdy = '0;
        busy     = (state_q == BURST);
        if (state_q == BURST) begin
            beat_rdy[gnt_q] = !dst_stalled;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            desc_q    <= '0;
            len_cnt_q <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            wen_q     <= '0;
            wdata_q   <= '0;
            waddr_q   <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            wen_q <= '0;
            if (state_q == IDLE && pick_any) begin
                gnt_q       <= pick;
                desc_q      <= pick_desc;
                len_cnt_q   <= '0;
                ack_q[pick] <= 1'b1;
                err_q       <= !dst_in_range(pick_desc.dst);
            end
            if (accept) begin
                len_cnt_q   <= len_cnt_q + 1'b1;
                desc_q.addr <= desc_q.addr + 1'b1;
                if (dst_ok) begin
                    wen_q[desc_q.dst[CIDX_W-1:0]] <= 1'b1;
                    wdata_q[dst_head(desc_q.dst)] <= cur_data;
                    waddr_q[dst_head(desc_q.dst)] <= desc_q.addr;
                end
                if (last_beat) begin
                    rr_ptr_q <= (gnt_q == GNT_W'(REQ_NUM - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
        end
    end

    assign req_ack      = ack_q;
    assign err_dst      = err_q;
    assign grant_id     = gnt_q;
    assign gbus_wen     = wen_q;
    assign gbus_wdata   = wdata_q;
    assign in_GBUS_ADDR = waddr_q;

endmodule

// File: tb/tb_gbus_wr_arbiter.sv
// Directed bench for gbus_wr_arbiter: grant, fairness, stall, wrap, reset abort, bad destination.
`timescale 1ns/1ps
module tb_gbus_wr_arbiter;
    import gbus_arb_pkg::*;

    logic                         clk = 1'b0;
    logic                         rstn;
    logic [REQ_NUM-1:0]           req_vld;
    logic [REQ_NUM*LEN_W-1:0]     req_len;
    logic [REQ_NUM*CORE_W-1:0]    req_dst;
    logic [REQ_NUM*GBUS_ADDR-1:0] req_addr;
    logic [REQ_NUM-1:0]           req_ack;
    logic [REQ_NUM-1:0]           beat_vld;
    logic [REQ_NUM*GBUS_DATA-1:0] beat_data;
    logic [REQ_NUM-1:0]           beat_rdy;
    logic [NCORE-1:0]             dst_stall;
    logic [NCORE-1:0]             gbus_wen;
    logic [HNUM*GBUS_DATA-1:0]    gbus_wdata;
    logic [HNUM*GBUS_ADDR-1:0]    in_GBUS_ADDR;
    logic                         busy;
    logic [GNT_W-1:0]             grant_id;
    logic                         err_dst;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gbus_wr_arbiter dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_vld      (req_vld),
        .req_len      (req_len),
        .req_dst      (req_dst),
        .req_addr     (req_addr),
        .req_ack      (req_ack),
        .beat_vld     (beat_vld),
        .beat_data    (beat_data),
        .beat_rdy     (beat_rdy),
        .dst_stall    (dst_stall),
        .gbus_wen     (gbus_wen),
        .gbus_wdata   (gbus_wdata),
        .in_GBUS_ADDR (in_GBUS_ADDR),
        .busy         (busy),
        .grant_id     (grant_id),
        .err_dst      (err_dst)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req_vld   = '0;
        req_len   = '0;
        req_dst   = '0;
        req_addr  = '0;
        beat_vld  = '0;
        beat_data = '0;
        dst_stall = '0;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        clear_inputs();
        tick();
        rstn = 1'b1;
    endtask

    task automatic set_req(input int r, input int len, input int dst, input int addr);
        req_len[r*LEN_W +: LEN_W]          = LEN_W'(len);
        req_dst[r*CORE_W +: CORE_W]        = CORE_W'(dst);
        req_addr[r*GBUS_ADDR +: GBUS_ADDR] = GBUS_ADDR'(addr);
    endtask

    task automatic set_beat(input int r, input logic [GBUS_DATA-1:0] d);
        beat_data[r*GBUS_DATA +: GBUS_DATA] = d;
    endtask

    function automatic logic [GBUS_DATA-1:0] pat(input int tag, input int k);
        return (64'(tag) << 32) | 64'(k) | 64'h00A5_0000_0000_0000;
    endfunction

    function automatic logic [NCORE-1:0] onehot(input int i);
        logic [NCORE-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic test_reset;
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        tests++; if (gbus_wen !== '0) begin fails++; $display("FAIL reset_wen got=%h exp=0", gbus_wen); end
        tests++; if (gbus_wdata !== '0) begin fails++; $display("FAIL reset_wdata got=%h exp=0", gbus_wdata); end
        tests++; if (in_GBUS_ADDR !== '0) begin fails++; $display("FAIL reset_addr got=%h exp=0", in_GBUS_ADDR); end
        tests++; if (req_ack !== '0) begin fails++; $display("FAIL reset_ack got=%b exp=0", req_ack); end
        tests++; if (beat_rdy !== '0) begin fails++; $display("FAIL reset_rdy got=%b exp=0", beat_rdy); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (grant_id !== '0) begin fails++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
        tests++; if (err_dst !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_dst); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single;
        set_req(0, 3, 10, 'h020);
        req_vld = 4'b0001;
        tick();
        tests++; if (req_ack !== 4'b0001) begin fails++; $display("FAIL single_ack got=%b exp=0001", req_ack); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got=%b exp=1", busy); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL single_gid got=%0d exp=0", grant_id); end
        req_vld = '0;
        for (int k = 0; k < 4; k++) begin
            set_beat(0, pat(1, k));
            beat_vld[0] = 1'b1;
            #1;
            tests++; if (beat_rdy !== 4'b0001) begin fails++; $display("FAIL single_rdy k=%0d got=%b exp=0001", k, beat_rdy); end
            tick();
            tests++; if (gbus_wen !== onehot(10)) begin fails++; $display("FAIL single_wen k=%0d got=%h exp=%h", k, gbus_wen, onehot(10)); end
            tests++; if (gbus_wdata[1*GBUS_DATA +: GBUS_DATA] !== pat(1, k)) begin fails++; $display("FAIL single_data k=%0d got=%h exp=%h", k, gbus_wdata[1*GBUS_DATA +: GBUS_DATA], pat(1, k)); end
            tests++; if (in_GBUS_ADDR[1*GBUS_ADDR +: GBUS_ADDR] !== GBUS_ADDR'('h020 + k)) begin fails++; $display("FAIL single_addr k=%0d got=%h exp=%h", k, in_GBUS_ADDR[1*GBUS_ADDR +: GBUS_ADDR], GBUS_ADDR'('h020 + k)); end
            if (k == 0) begin
                tests++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL single_ack_once got=%b exp=0000", req_ack); end
            end
        end
        beat_vld = '0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle got=%b exp=0", busy); end
        tick();
        tests++; if (gbus_wen !== '0) begin fails++; $display("FAIL single_wen_off got=%h exp=0", gbus_wen); end
        tests++; if (gbus_wdata[1*GBUS_DATA +: GBUS_DATA] !== pat(1, 3)) begin fails++; $display("FAIL single_data_hold got=%h exp=%h", gbus_wdata[1*GBUS_DATA +: GBUS_DATA], pat(1, 3)); end
        tests++; if (in_GBUS_ADDR[1*GBUS_ADDR +: GBUS_ADDR] !== 12'h023) begin fails++; $display("FAIL single_addr_hold got=%h exp=023", in_GBUS_ADDR[1*GBUS_ADDR +: GBUS_ADDR]); end
    endtask

    task automatic test_fairness;
        logic [REQ_NUM-1:0] exp_ack;
        logic [NCORE-1:0]   exp_wen;
        int                 g;
        do_reset();
        for (int r = 0; r < REQ_NUM; r++) begin
            set_req(r, 0, r, r * 16);
            set_beat(r, pat(2, r));
        end
        req_vld  = 4'b1111;
        beat_vld = 4'b1111;
        for (int c = 1; c <= 10; c++) begin
            tick();
            g       = ((c - 1) / 2) % 4;
            exp_ack = (c % 2 == 1) ? (4'b0001 << g) : 4'b0000;
            exp_wen = (c % 2 == 0) ? onehot(((c - 2) / 2) % 4) : '0;
            tests++; if (req_ack !== exp_ack) begin fails++; $display("FAIL fair_ack c=%0d got=%b exp=%b", c, req_ack, exp_ack); end
            tests++; if (busy !== (c % 2 == 1)) begin fails++; $display("FAIL fair_busy c=%0d got=%b exp=%b", c, busy, (c % 2 == 1)); end
            tests++; if (grant_id !== GNT_W'(g)) begin fails++; $display("FAIL fair_gid c=%0d got=%0d exp=%0d", c, grant_id, g); end
            tests++; if (gbus_wen !== exp_wen) begin fails++; $display("FAIL fair_wen c=%0d got=%h exp=%h", c, gbus_wen, exp_wen); end
            if (c % 2 == 0) begin
                tests++; if (gbus_wdata[GBUS_DATA-1:0] !== pat(2, g)) begin fails++; $display("FAIL fair_data c=%0d got=%h exp=%h", c, gbus_wdata[GBUS_DATA-1:0], pat(2, g)); end
            end
            if (c == 10) begin
                req_vld  = '0;
                beat_vld = '0;
            end
        end
    endtask

    task automatic test_backpressure;
        int   nb;
        int   exp_w;
        logic stall;
        logic exp_rdy;
        nb    = 0;
        exp_w = -1;
        set_req(0, 3, 10, 'h040);
        req_vld = 4'b0001;
        for (int c = 1; c <= 9; c++) begin
            tick();
            req_vld = '0;
            if (exp_w >= 0) begin
                tests++; if (gbus_wen !== onehot(10)) begin fails++; $display("FAIL bp_wen c=%0d got=%h exp=%h", c, gbus_wen, onehot(10)); end
                tests++; if (gbus_wdata[1*GBUS_DATA +: GBUS_DATA] !== pat(3, exp_w)) begin fails++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, gbus_wdata[1*GBUS_DATA +: GBUS_DATA], pat(3, exp_w)); end
                tests++; if (in_GBUS_ADDR[1*GBUS_ADDR +: GBUS_ADDR] !== GBUS_ADDR'('h040 + exp_w)) begin fails++; $display("FAIL bp_addr c=%0d got=%h exp=%h", c, in_GBUS_ADDR[1*GBUS_ADDR +: GBUS_ADDR], GBUS_ADDR'('h040 + exp_w)); end
            end else begin
                tests++; if (gbus_wen !== '0) begin fails++; $display("FAIL bp_wen_off c=%0d got=%h exp=0", c, gbus_wen); end
            end
            stall         = (c >= 2 && c <= 4);
            dst_stall[10] = stall;
            beat_vld[0]   = (nb < 4);
            set_beat(0, pat(3, nb));
            #1;
            exp_rdy = (nb < 4) && !stall;
            tests++; if (beat_rdy !== {3'b000, exp_rdy}) begin fails++; $display("FAIL bp_rdy c=%0d got=%b exp=%b", c, beat_rdy, {3'b000, exp_rdy}); end
            if (exp_rdy) begin
                exp_w = nb;
                nb++;
            end else begin
                exp_w = -1;
            end
        end
        beat_vld  = '0;
        dst_stall = '0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle got=%b exp=0", busy); end
    endtask

    task automatic test_addr_wrap;
        set_req(1, 3, 20, 'hFFE);
        req_vld = 4'b0010;
        tick();
        tests++; if (req_ack !== 4'b0010) begin fails++; $display("FAIL wrap_ack got=%b exp=0010", req_ack); end
        tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL wrap_gid got=%0d exp=1", grant_id); end
        req_vld = '0;
        for (int k = 0; k < 4; k++) begin
            set_beat(1, pat(4, k));
            beat_vld[1] = 1'b1;
            tick();
            tests++; if (gbus_wen !== onehot(20)) begin fails++; $display("FAIL wrap_wen k=%0d got=%h exp=%h", k, gbus_wen, onehot(20)); end
            tests++; if (in_GBUS_ADDR[2*GBUS_ADDR +: GBUS_ADDR] !== GBUS_ADDR'('hFFE + k)) begin fails++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, in_GBUS_ADDR[2*GBUS_ADDR +: GBUS_ADDR], GBUS_ADDR'('hFFE + k)); end
            tests++; if (gbus_wdata[2*GBUS_DATA +: GBUS_DATA] !== pat(4, k)) begin fails++; $display("FAIL wrap_data k=%0d got=%h exp=%h", k, gbus_wdata[2*GBUS_DATA +: GBUS_DATA], pat(4, k)); end
        end
        beat_vld = '0;
    endtask

    task automatic test_reset_mid;
        set_req(2, 3, 10, 'h200);
        req_vld = 4'b0100;
        tick();
        tests++; if (req_ack !== 4'b0100) begin fails++; $display("FAIL rmid_ack got=%b exp=0100", req_ack); end
        req_vld     = '0;
        beat_vld[2] = 1'b1;
        set_beat(2, pat(5, 0));
        tick();
        tests++; if (gbus_wdata[1*GBUS_DATA +: GBUS_DATA] !== pat(5, 0)) begin fails++; $display("FAIL rmid_b0 got=%h exp=%h", gbus_wdata[1*GBUS_DATA +: GBUS_DATA], pat(5, 0)); end
        set_beat(2, pat(5, 1));
        tick();
        tests++; if (gbus_wen !== onehot(10)) begin fails++; $display("FAIL rmid_b1_wen got=%h exp=%h", gbus_wen, onehot(10)); end
        set_beat(2, pat(5, 2));
        rstn = 1'b0;
        tick();
        tests++; if (gbus_wen !== '0) begin fails++; $display("FAIL rmid_wen got=%h exp=0", gbus_wen); end
        tests++; if (gbus_wdata !== '0) begin fails++; $display("FAIL rmid_wdata got=%h exp=0", gbus_wdata); end
        tests++; if (in_GBUS_ADDR !== '0) begin fails++; $display("FAIL rmid_addr got=%h exp=0", in_GBUS_ADDR); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        tests++; if (grant_id !== '0) begin fails++; $display("FAIL rmid_gid got=%0d exp=0", grant_id); end
        tests++; if (beat_rdy !== '0) begin fails++; $display("FAIL rmid_rdy got=%b exp=0", beat_rdy); end
        rstn     = 1'b1;
        beat_vld = '0;
        set_req(1, 0, 5, 'h0AA);
        set_req(3, 0, 40, 'h0BB);
        req_vld = 4'b1010;
        tick();
        tests++; if (req_ack !== 4'b0010) begin fails++; $display("FAIL rmid_regrant_ack got=%b exp=0010", req_ack); end
        tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL rmid_regrant_gid got=%0d exp=1", grant_id); end
        req_vld     = '0;
        beat_vld[1] = 1'b1;
        set_beat(1, pat(6, 0));
        tick();
        tests++; if (gbus_wen !== onehot(5)) begin fails++; $display("FAIL rmid_new_wen got=%h exp=%h", gbus_wen, onehot(5)); end
        tests++; if (in_GBUS_ADDR[GBUS_ADDR-1:0] !== 12'h0AA) begin fails++; $display("FAIL rmid_new_addr got=%h exp=0aa", in_GBUS_ADDR[GBUS_ADDR-1:0]); end
        tests++; if (gbus_wdata[GBUS_DATA-1:0] !== pat(6, 0)) begin fails++; $display("FAIL rmid_new_data got=%h exp=%h", gbus_wdata[GBUS_DATA-1:0], pat(6, 0)); end
        beat_vld = '0;
    endtask

    task automatic test_bad_dst;
        set_req(2, 1, 64, 'h100);
        req_vld   = 4'b0100;
        dst_stall = '1;
        tick();
        tests++; if (err_dst !== 1'b1) begin fails++; $display("FAIL bad_err got=%b exp=1", err_dst); end
        tests++; if (req_ack !== 4'b0100) begin fails++; $display("FAIL bad_ack got=%b exp=0100", req_ack); end
        req_vld     = '0;
        beat_vld[2] = 1'b1;
        set_beat(2, pat(7, 0));
        #1;
        tests++; if (beat_rdy !== 4'b0100) begin fails++; $display("FAIL bad_rdy0 got=%b exp=0100", beat_rdy); end
        tick();
        tests++; if (err_dst !== 1'b0) begin fails++; $display("FAIL bad_err_pulse got=%b exp=0", err_dst); end
        tests++; if (gbus_wen !== '0) begin fails++; $display("FAIL bad_wen0 got=%h exp=0", gbus_wen); end
        set_beat(2, pat(7, 1));
        #1;
        tests++; if (beat_rdy !== 4'b0100) begin fails++; $display("FAIL bad_rdy1 got=%b exp=0100", beat_rdy); end
        tick();
        tests++; if (gbus_wen !== '0) begin fails++; $display("FAIL bad_wen1 got=%h exp=0", gbus_wen); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bad_drained got=%b exp=0", busy); end
        tests++; if (gbus_wdata[GBUS_DATA-1:0] !== pat(6, 0)) begin fails++; $display("FAIL bad_head0_hold got=%h exp=%h", gbus_wdata[GBUS_DATA-1:0], pat(6, 0)); end
        beat_vld  = '0;
        dst_stall = '0;
        set_req(3, 0, 63, 'h7AB);
        req_vld = 4'b1000;
        tick();
        tests++; if (req_ack !== 4'b1000) begin fails++; $display("FAIL bad_next_ack got=%b exp=1000", req_ack); end
        tests++; if (err_dst !== 1'b0) begin fails++; $display("FAIL bad_next_err got=%b exp=0", err_dst); end
        req_vld     = '0;
        beat_vld[3] = 1'b1;
        set_beat(3, pat(8, 0));
        tick();
        tests++; if (gbus_wen !== onehot(63)) begin fails++; $display("FAIL bad_next_wen got=%h exp=%h", gbus_wen, onehot(63)); end
        tests++; if (in_GBUS_ADDR[7*GBUS_ADDR +: GBUS_ADDR] !== 12'h7AB) begin fails++; $display("FAIL bad_next_addr got=%h exp=7ab", in_GBUS_ADDR[7*GBUS_ADDR +: GBUS_ADDR]); end
        tests++; if (gbus_wdata[7*GBUS_DATA +: GBUS_DATA] !== pat(8, 0)) begin fails++; $display("FAIL bad_next_data got=%h exp=%h", gbus_wdata[7*GBUS_DATA +: GBUS_DATA], pat(8, 0)); end
        beat_vld = '0;
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_addr_wrap();
        test_reset_mid();
        test_bad_dst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
